rf_dump_reader: RTL and testbench

- Sequential reader that scans the CPU register file through a dedicated read port and streams every register out as 16-bit halves over a valid/ready handshake.
- Sits beside the register file. It feeds the debug/display path (seven-segment or serial dump) with a coherent register snapshot, so single-register switch selection is no longer needed.
- Snoops the register-file write port so that a write landing on the register being sampled is not lost.

---
 rtl/rf_dump_reader.sv | 99 +++++++++
 tb/tb_rf_dump_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks every register through a read port and streams each
// one out as two 16-bit halves on a valid/ready handshake, snooping the write port.
module rf_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter bit          HI_FIRST   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [15:0]           out_data_o,
  output logic [ADDR_WIDTH-1:0] out_reg_o,
  output logic                  out_half_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StSendA, StSendB, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           word_q, word_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        // r0 reads as zero; a same-cycle write to idx has not reached rd_data yet.
        if (idx_q == '0) begin
          word_d = '0;
        end else if (wr_en_i && (wr_addr_i == idx_q)) begin
          word_d = wr_data_i;
        end else begin
          word_d = rd_data_i;
        end
        state_d = StSendA;
      end
      StSendA: begin
        if (out_ready_i) state_d = StSendB;
      end
      StSendB: begin
        if (out_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic send_hi;

  always_comb begin
    out_valid_o = (state_q == StSendA) || (state_q == StSendB);
    send_hi     = (state_q == StSendB) ^ HI_FIRST;
    out_half_o  = out_valid_o & send_hi;
    out_reg_o   = out_valid_o ? idx_q : '0;
    out_data_o  = '0;
    if (out_valid_o) out_data_o = send_hi ? word_q[31:16] : word_q[15:0];
    rd_addr_o   = (state_q == StIdle) ? '0 : idx_q;
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboard bench for rf_dump_reader: two instances (HI_FIRST=0 and 1) run in lockstep
// against a register-file model; a monitor pops expected beats on every accepted handshake.
module tb_rf_dump_reader;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset, start, wr_en, out_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic [AW-1:0] rd_addr, out_reg, rd_addr_h, out_reg_h;
  logic [31:0]   rd_data, rd_data_h;
  logic [15:0]   out_data, out_data_h;
  logic          out_valid, out_half, busy, done;
  logic          out_valid_h, out_half_h, busy_h, done_h;

  logic [31:0] mem [NR];

  assign rd_data   = mem[rd_addr];
  assign rd_data_h = mem[rd_addr_h];

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  rf_dump_reader #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .HI_FIRST(1'b0)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_reg_o(out_reg),
    .out_half_o(out_half), .busy_o(busy), .done_o(done)
  );

  rf_dump_reader #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .HI_FIRST(1'b1)) dut_hi (
    .clk_i(clk), .reset_i(reset), .start_i(start), .rd_addr_o(rd_addr_h),
    .rd_data_i(rd_data_h), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .out_valid_o(out_valid_h), .out_ready_i(out_ready), .out_data_o(out_data_h),
    .out_reg_o(out_reg_h), .out_half_o(out_half_h), .busy_o(busy_h), .done_o(done_h)
  );

  typedef struct packed {
    logic [15:0]   data;
    logic [AW-1:0] r;
    logic          half;
  } beat_t;

  beat_t q[$];
  beat_t qh[$];
  int tests = 0;
  int fails = 0;
  int beats = 0;
  int dones = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Low-first queue for dut, high-first queue for dut_hi.
  task automatic push_beats(input int r, input logic [31:0] w, input bit first_only);
    q.push_back({w[15:0], AW'(r), 1'b0});
    qh.push_back({w[31:16], AW'(r), 1'b1});
    if (!first_only) begin
      q.push_back({w[31:16], AW'(r), 1'b1});
      qh.push_back({w[15:0], AW'(r), 1'b0});
    end
  endtask

  task automatic push_dump(input int last, input logic [31:0] r7);
    logic [31:0] w;
    for (int i = 0; i <= last; i++) begin
      w = (i == 0) ? 32'h0 : (i == 7) ? r7 : 32'hA5A5_0000 + 32'(i);
      push_beats(i, w, 1'b0);
    end
  endtask

  // Monitor samples just after the negedge, when stimulus for the coming edge is settled.
  always @(negedge clk) begin
    beat_t e;
    #1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      beats++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra beat (lo-first): got %0h, expected none",
                 {out_data, out_reg, out_half});
      end else begin
        e = q.pop_front();
        check($sformatf("beat lo-first r%0d", e.r), {out_data, out_reg, out_half}, e);
      end
    end
    if (out_valid_h === 1'b1 && out_ready === 1'b1) begin
      if (qh.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra beat (hi-first): got %0h, expected none",
                 {out_data_h, out_reg_h, out_half_h});
      end else begin
        e = qh.pop_front();
        check($sformatf("beat hi-first r%0d", e.r), {out_data_h, out_reg_h, out_half_h}, e);
      end
    end
    if (done === 1'b1) dones++;
  end

  function automatic bit hit(input int r, input int kind);
    case (kind)
      0:       return busy && !out_valid && !done && (rd_addr == AW'(r));
      1:       return out_valid && (out_reg == AW'(r)) && !out_half;
      default: return out_valid && (out_reg == AW'(r)) && out_half;
    endcase
  endfunction

  task automatic wait_for(input int r, input int kind, input string name);
    int n = 0;
    while (!hit(r, kind) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL %s: timed out, expected state not reached", name);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_dump(input string name, input int b0, input int n0);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, " done seen"}, done, 1'b1);
    @(negedge clk);
    check({name, " idle after done"}, {done, busy, out_valid}, 3'b000);
    check({name, " beat count"}, beats - b0, 2 * NR);
    check({name, " queues drained"}, q.size() + qh.size(), 0);
    check({name, " done pulses"}, dones - n0, 1);
  endtask

  int b0, n0, cnt;

  initial begin
    for (int i = 0; i < NR; i++) mem[i] = (i == 0) ? 32'hFFFF_FFFF : 32'hA5A5_0000 + 32'(i);
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset idle", {out_valid, busy, done, rd_addr, out_valid_h}, '0);
    end

    // Full dump with ready held high; DONE lands 3*NR+1 cycles after the start edge.
    push_dump(NR - 1, 32'hA5A5_0007);
    b0 = beats; n0 = dones;
    pulse_start();
    check("read r0 cycle", {busy, out_valid, rd_addr}, {1'b1, 1'b0, 5'd0});
    @(negedge clk);
    check("first beat", {out_valid, out_data, out_reg, out_half}, {1'b1, 16'h0, 5'd0, 1'b0});
    cnt = 2;
    while (!done && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("done latency", cnt, 3 * NR + 1);
    finish_dump("full", b0, n0);

    // Backpressure on reg 3, then write bypass and post-capture write on reg 7.
    push_dump(NR - 1, 32'h1234_5678);
    b0 = beats; n0 = dones;
    pulse_start();
    wait_for(3, 0, "read r3");
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("stall hold r3", {out_valid, out_data, out_reg, out_half},
            {1'b1, 16'h0003, 5'd3, 1'b0});
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_for(7, 0, "read r7");
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
    @(negedge clk);
    wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en = 1'b0;
    finish_dump("bypass", b0, n0);

    // Reset during SEND_B of reg 10: regs 0..9 and the first half of reg 10 go out.
    push_dump(9, 32'hDEAD_BEEF);
    push_beats(10, 32'hA5A5_000A, 1'b1);
    n0 = dones;
    pulse_start();
    wait_for(10, 2, "send_b r10");
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("reset abort", {out_valid, busy, done, rd_addr, out_valid_h}, '0);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort no done", dones - n0, 0);
    check("abort queues", q.size() + qh.size(), 0);

    // Restart from reg 0; a second start while busy must be dropped.
    push_dump(NR - 1, 32'hDEAD_BEEF);
    b0 = beats; n0 = dones;
    pulse_start();
    wait_for(2, 1, "send_a r2");
    pulse_start();
    finish_dump("restart", b0, n0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
